// File: rtl/ps2_mouse_pkg.sv
// Shared constants, FSM state encoding and the init command table for the PS/2 mouse controller.
package ps2_mouse_pkg;

    localparam logic [7:0] CmdReset   = 8'hFF;
    localparam logic [7:0] CmdEnable  = 8'hF4;
    localparam logic [7:0] CmdSetRate = 8'hF3;
    localparam logic [7:0] CmdGetId   = 8'hF2;

    localparam logic [7:0] RspAck     = 8'hFA;
    localparam logic [7:0] RspBatOk   = 8'hAA;
    localparam logic [7:0] RspBatErr  = 8'hFC;
    localparam logic [7:0] RspIdWheel = 8'h03;
    localparam logic [7:0] RspZero    = 8'h00;

    // Sample-rate sequence 200, 100, 80 unlocks IntelliMouse wheel reporting.
    localparam logic [7:0] RateMagic0 = 8'hC8;
    localparam logic [7:0] RateMagic1 = 8'h64;
    localparam logic [7:0] RateMagic2 = 8'h50;

    typedef enum logic [3:0] {
        StCmdIssue,
        StCmdWait,
        StAckWait,
        StBatAa,
        StBatZero,
        StIdWait,
        StRetry,
        StFail,
        StB0,
        StB1,
        StB2,
        StB3
    } state_e;

    function automatic logic [7:0] cmd_byte(input bit wheel_en, input logic [3:0] idx);
        logic [7:0] c;
        c = CmdEnable;
        if (wheel_en) begin
            case (idx)
                4'd0:             c = CmdReset;
                4'd1, 4'd3, 4'd5: c = CmdSetRate;
                4'd2:             c = RateMagic0;
                4'd4:             c = RateMagic1;
                4'd6:             c = RateMagic2;
                4'd7:             c = CmdGetId;
                default:          c = CmdEnable;
            endcase
        end else begin
            case (idx)
                4'd0:    c = CmdReset;
                4'd1:    c = CmdGetId;
                default: c = CmdEnable;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ps2_mouse_timeout.sv
// Loadable down-counter: clear reloads the full window, expired is high once it has run out.
module ps2_mouse_timeout #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= CW'(TIMEOUT_CYC);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse controller: init handshake with retry, wheel detection, and packet decode into
// buttons, saturating absolute position and a wrapping wheel counter.
module ps2_mouse_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned POS_W       = 10,
    parameter bit          WHEEL_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_en,
    output logic             tx_load,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic [2:0]       buttons,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [7:0]       wheel,
    output logic             pkt_strobe,
    output logic             ready,
    output logic             wheel_present,
    output logic             init_fail
);

    // Position plus a 9-bit signed delta fits in POS_W+2 signed bits (POS_W >= 8).
    localparam int unsigned AW = POS_W + 2;

    state_e state_q, state_d;

    logic [3:0]       cmd_idx_q;
    logic [7:0]       retry_q;
    logic             tx_load_q;
    logic [7:0]       tx_data_q;
    logic             wheel_present_q;
    logic [7:0]       b0_q, b1_q, b2_q;
    logic [2:0]       buttons_q;
    logic [POS_W-1:0] pos_x_q, pos_y_q;
    logic [7:0]       wheel_q;
    logic             pkt_strobe_q;

    logic             rx_ok;
    logic             pkt_done;
    logic             timer_clear;
    logic             timer_expired;

    logic [7:0]          b2_cur;
    logic [3:0]          b3_nib;
    logic signed [AW-1:0] dx, dy, nx, ny;
    logic [POS_W-1:0]    pos_x_new, pos_y_new;
    logic [7:0]          wheel_new;

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [AW-1:0] v);
        if (v[AW-1]) return '0;
        if (v[POS_W]) return '1;
        return v[POS_W-1:0];
    endfunction

    assign rx_ok       = rx_valid && rx_en;
    assign pkt_done    = rx_ok && ((state_q == StB2 && !wheel_present_q) || state_q == StB3);
    assign timer_clear = (state_d != state_q) || rx_ok;

    ps2_mouse_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StCmdIssue;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCmdIssue: if (!tx_busy) state_d = StCmdWait;
            // Hold until the transmitter has had a cycle to raise busy for our load.
            StCmdWait: if (!tx_busy && !tx_load_q) state_d = StAckWait;
            StAckWait: begin
                if (rx_ok) begin
                    if (rx_data != RspAck)          state_d = StRetry;
                    else if (tx_data_q == CmdReset)  state_d = StBatAa;
                    else if (tx_data_q == CmdGetId)  state_d = StIdWait;
                    else if (tx_data_q == CmdEnable) state_d = StB0;
                    else                             state_d = StCmdIssue;
                end else if (timer_expired) begin
                    state_d = StRetry;
                end
            end
            StBatAa: begin
                if (rx_ok)              state_d = (rx_data == RspBatOk) ? StBatZero : StRetry;
                else if (timer_expired) state_d = StRetry;
            end
            StBatZero: begin
                if (rx_ok)              state_d = (rx_data == RspZero) ? StCmdIssue : StRetry;
                else if (timer_expired) state_d = StRetry;
            end
            StIdWait: begin
                if (rx_ok) begin
                    state_d = (rx_data == RspIdWheel || rx_data == RspZero) ? StCmdIssue : StRetry;
                end else if (timer_expired) begin
                    state_d = StRetry;
                end
            end
            StRetry: state_d = (retry_q == 8'(MAX_RETRY - 1)) ? StFail : StCmdIssue;
            StFail:  state_d = StFail;
            StB0: if (rx_ok && rx_data[3]) state_d = StB1;
            StB1: begin
                // AA,00 in the first two slots is a hot-plug BAT, not motion.
                if (rx_ok) state_d = (b0_q == RspBatOk && rx_data == RspZero) ? StCmdIssue : StB2;
                else if (timer_expired) state_d = StB0;
            end
            StB2: begin
                if (rx_ok)              state_d = wheel_present_q ? StB3 : StB0;
                else if (timer_expired) state_d = StB0;
            end
            StB3: if (rx_ok || timer_expired) state_d = StB0;
            default: state_d = StCmdIssue;
        endcase
    end

    always_comb begin
        b2_cur    = (state_q == StB2) ? rx_data : b2_q;
        b3_nib    = (state_q == StB3) ? rx_data[3:0] : 4'h0;
        dx        = b0_q[6] ? '0 : AW'($signed({b0_q[4], b1_q}));
        dy        = b0_q[7] ? '0 : AW'($signed({b0_q[5], b2_cur}));
        nx        = $signed({2'b00, pos_x_q}) + dx;
        ny        = $signed({2'b00, pos_y_q}) - dy;
        pos_x_new = clamp_pos(nx);
        pos_y_new = clamp_pos(ny);
        wheel_new = wheel_q + {{4{b3_nib[3]}}, b3_nib};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_idx_q       <= '0;
            retry_q         <= '0;
            tx_load_q       <= 1'b0;
            tx_data_q       <= '0;
            wheel_present_q <= 1'b0;
            b0_q            <= '0;
            b1_q            <= '0;
            b2_q            <= '0;
            buttons_q       <= '0;
            pos_x_q         <= '0;
            pos_y_q         <= '0;
            wheel_q         <= '0;
            pkt_strobe_q    <= 1'b0;
        end else begin
            tx_load_q    <= 1'b0;
            pkt_strobe_q <= 1'b0;
            if (state_q == StCmdIssue && !tx_busy) begin
                tx_load_q <= 1'b1;
                tx_data_q <= cmd_byte(WHEEL_EN, cmd_idx_q);
            end
            if (state_d == StCmdIssue) begin
                if (state_q inside {StAckWait, StBatZero, StIdWait}) begin
                    cmd_idx_q <= cmd_idx_q + 4'd1;
                end else if (state_q == StRetry) begin
                    cmd_idx_q <= '0;
                end else if (state_q == StB1) begin
                    cmd_idx_q       <= '0;
                    retry_q         <= '0;
                    wheel_present_q <= 1'b0;
                end
            end
            if (state_q == StRetry) retry_q <= retry_q + 8'd1;
            if (state_q == StIdWait && rx_ok) wheel_present_q <= (rx_data == RspIdWheel);
            if (rx_ok && state_q == StB0) b0_q <= rx_data;
            if (rx_ok && state_q == StB1) b1_q <= rx_data;
            if (rx_ok && state_q == StB2) b2_q <= rx_data;
            if (pkt_done) begin
                buttons_q    <= b0_q[2:0];
                pos_x_q      <= pos_x_new;
                pos_y_q      <= pos_y_new;
                wheel_q      <= wheel_new;
                pkt_strobe_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rx_en         = (state_q != StCmdWait);
        ready         = (state_q inside {StB0, StB1, StB2, StB3});
        init_fail     = (state_q == StFail);
        tx_load       = tx_load_q;
        tx_data       = tx_data_q;
        wheel_present = wheel_present_q;
        buttons       = buttons_q;
        pos_x         = pos_x_q;
        pos_y         = pos_y_q;
        wheel         = wheel_q;
        pkt_strobe    = pkt_strobe_q;
    end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: scripted device responses, a behavioural packet model and a
// per-cycle comparison of the decoded outputs.
module tb_ps2_mouse_decoder;

    localparam int POS_W = 10;
    localparam int TMO   = 40;
    localparam int PMAX  = (1 << POS_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_en, tx_load, tx_busy;
    logic [7:0]       tx_data;
    logic [2:0]       buttons;
    logic [POS_W-1:0] pos_x, pos_y;
    logic [7:0]       wheel;
    logic             pkt_strobe, ready, wheel_present, init_fail;

    int n_cmp = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int tx_cnt = 0;
    int busy_viol = 0;

    int m_x = 0, m_y = 0, m_wheel = 0, m_buttons = 0, m_pkts = 0;
    int seen_pkts = 0;
    bit cmp_en = 1'b0;

    ps2_mouse_decoder #(
        .POS_W      (POS_W),
        .WHEEL_EN   (1'b1),
        .TIMEOUT_CYC(TMO),
        .MAX_RETRY  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .tx_load      (tx_load),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .buttons      (buttons),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .wheel        (wheel),
        .pkt_strobe   (pkt_strobe),
        .ready        (ready),
        .wheel_present(wheel_present),
        .init_fail    (init_fail)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: busy for a few cycles after each load.
    assign tx_busy = (busy_cnt != 0);
    always @(negedge clk) begin
        if (tx_load) begin
            if (tx_busy) busy_viol <= busy_viol + 1;
            busy_cnt <= 4;
            tx_cnt   <= tx_cnt + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    function automatic void model_packet(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input bit four);
        int dx, dy, w;
        dx = int'(b1);
        if (b0[4]) dx = dx - 256;
        if (b0[6]) dx = 0;
        dy = int'(b2);
        if (b0[5]) dy = dy - 256;
        if (b0[7]) dy = 0;
        m_x = clampi(m_x + dx);
        m_y = clampi(m_y - dy);
        if (four) begin
            w = int'(b3[3:0]);
            if (w > 7) w = w - 16;
            m_wheel = (m_wheel + w + 256) % 256;
        end
        m_buttons = int'(b0[2:0]);
        m_pkts++;
    endfunction

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("buttons", int'(buttons), m_buttons);
            chk("pos_x", int'(pos_x), m_x);
            chk("pos_y", int'(pos_y), m_y);
            chk("wheel", int'(wheel), m_wheel);
            chk("pkt_strobe", int'(pkt_strobe), (m_pkts != seen_pkts) ? 1 : 0);
        end
        seen_pkts = m_pkts;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit four);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        if (four) send_byte(b3);
        model_packet(b0, b1, b2, b3, four);
    endtask

    task automatic expect_cmd(input logic [7:0] c, input bit poke);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!tx_load && t < 100);
        if (!tx_load) begin
            chk("tx_load_seen", 0, 1);
            return;
        end
        chk("tx_data", int'(tx_data), int'(c));
        if (poke) begin
            chk("rx_en_low_while_sending", int'(rx_en), 0);
            send_byte(8'hFE);
        end
        t = 0;
        while (!(rx_en && !tx_busy) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rx_en_after_send", int'(rx_en), 1);
    endtask

    task automatic do_reset(input logic [7:0] junk);
        @(negedge clk);
        cmp_en   = 1'b0;
        rst_n    = 1'b0;
        rx_data  = junk;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("rst_rx_en", int'(rx_en), 1);
        chk("rst_tx_load", int'(tx_load), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_buttons", int'(buttons), 0);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_pos_y", int'(pos_y), 0);
        chk("rst_wheel", int'(wheel), 0);
        chk("rst_pkt_strobe", int'(pkt_strobe), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_wheel_present", int'(wheel_present), 0);
        chk("rst_init_fail", int'(init_fail), 0);
        m_x = 0;
        m_y = 0;
        m_wheel = 0;
        m_buttons = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
    endtask

    task automatic do_init(input logic [7:0] id_rsp);
        logic [7:0] seq [9];
        seq = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
        for (int i = 0; i < 9; i++) begin
            expect_cmd(seq[i], i == 0);
            send_byte(8'hFA);
            if (seq[i] == 8'hFF) begin
                send_byte(8'hAA);
                send_byte(8'h00);
            end
            if (seq[i] == 8'hF2) send_byte(id_rsp);
        end
        chk("init_ready", int'(ready), 1);
        chk("init_wheel_present", int'(wheel_present), (id_rsp == 8'h03) ? 1 : 0);
    endtask

    initial begin
        int tx0;

        do_reset(8'h00);
        do_init(8'h03);

        // 4-byte packets
        send_pkt(8'h08, 8'h03, 8'h00, 8'h00, 1'b1);
        chk("lit_pos_x_3", int'(pos_x), 3);
        send_pkt(8'h18, 8'hF0, 8'h00, 8'h0F, 1'b1);
        chk("lit_pos_x_clamp_low", int'(pos_x), 0);
        chk("lit_wheel_ff", int'(wheel), 255);

        // hot-plug BAT in stream mode
        send_byte(8'hAA);
        send_byte(8'h00);
        chk("hotplug_ready", int'(ready), 0);
        chk("hotplug_wheel_present", int'(wheel_present), 0);

        // device refuses every reset
        for (int i = 0; i < 3; i++) begin
            expect_cmd(8'hFF, 1'b0);
            send_byte(8'hFE);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("fail_init_fail", int'(init_fail), 1);
        chk("fail_ready", int'(ready), 0);
        chk("fail_rx_en", int'(rx_en), 1);
        tx0 = tx_cnt;
        repeat (TMO + 20) @(posedge clk);
        #1;
        chk("fail_no_more_tx", tx_cnt - tx0, 0);

        // re-init as a plain 3-byte mouse
        do_reset(8'h09);
        do_init(8'h00);

        send_pkt(8'h29, 8'h05, 8'hFD, 8'h00, 1'b0);
        chk("lit_buttons_001", int'(buttons), 1);
        chk("lit_pos_x_5", int'(pos_x), 5);
        chk("lit_pos_y_3", int'(pos_y), 3);

        // partial packet abandoned by timeout
        send_byte(8'h08);
        send_byte(8'h10);
        repeat (TMO + 10) @(posedge clk);
        send_pkt(8'h0A, 8'h01, 8'h01, 8'h00, 1'b0);
        chk("lit_buttons_010", int'(buttons), 2);
        chk("lit_pos_x_6", int'(pos_x), 6);
        chk("lit_pos_y_2", int'(pos_y), 2);

        // out-of-sync first byte is dropped
        send_byte(8'h00);
        send_pkt(8'h08, 8'h02, 8'h00, 8'h00, 1'b0);
        chk("lit_pos_x_8", int'(pos_x), 8);

        // overflow bits zero the corresponding delta
        send_pkt(8'h48, 8'h7F, 8'h01, 8'h00, 1'b0);
        send_pkt(8'h88, 8'h01, 8'h7F, 8'h00, 1'b0);
        chk("lit_ovf_pos_x_9", int'(pos_x), 9);
        chk("lit_ovf_pos_y_1", int'(pos_y), 1);

        // saturate at the top
        for (int i = 0; i < 5; i++) send_pkt(8'h08, 8'hFF, 8'h00, 8'h00, 1'b0);
        chk("lit_pos_x_max", int'(pos_x), PMAX);

        // reset in the middle of a packet
        send_byte(8'h08);
        send_byte(8'h01);
        do_reset(8'h08);
        expect_cmd(8'hFF, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("tx_load_while_busy", busy_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
